// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared widths and controller state encoding for the AES CTR
//            sequencing controller and its stream/core interface.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int BLOCK_W = 128;
  localparam int CTR_W   = 64;
  localparam int NONCE_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_KEY_ISSUE = 3'd1,
    ST_KEY_ARM   = 3'd2,
    ST_KEY_WAIT  = 3'd3,
    ST_BLK_ISSUE = 3'd4,
    ST_BLK_ARM   = 3'd5,
    ST_BLK_WAIT  = 3'd6,
    ST_OUT       = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/aes_ctr_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_ctr_sched_if
// Purpose  : Bundles the configuration, plaintext stream, ciphertext stream
//            and AES core control signals of the CTR sequencing controller.
//            master = controller side, slave = environment side.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_ctr_sched_if;
  import aes_pkg::*;

  logic                 cfg_key_valid;
  logic [BLOCK_W-1:0]   cfg_key;
  logic [NONCE_W-1:0]   cfg_nonce;
  logic                 cfg_key_ready;
  logic                 key_loaded;
  logic                 in_valid;
  logic [BLOCK_W-1:0]   in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [BLOCK_W-1:0]   out_data;
  logic                 out_ready;
  logic                 core_init;
  logic                 core_next;
  logic [BLOCK_W-1:0]   core_key;
  logic [BLOCK_W-1:0]   core_block;
  logic                 core_ready;
  logic [BLOCK_W-1:0]   core_result;
  logic [CTR_W-1:0]     blk_count;
  logic                 err_wrap;
  logic                 err_timeout;

  modport master (
    input  cfg_key_valid, cfg_key, cfg_nonce, in_valid, in_data, out_ready,
           core_ready, core_result,
    output cfg_key_ready, key_loaded, in_ready, out_valid, out_data,
           core_init, core_next, core_key, core_block, blk_count,
           err_wrap, err_timeout
  );

  modport slave (
    output cfg_key_valid, cfg_key, cfg_nonce, in_valid, in_data, out_ready,
           core_ready, core_result,
    input  cfg_key_ready, key_loaded, in_ready, out_valid, out_data,
           core_init, core_next, core_key, core_block, blk_count,
           err_wrap, err_timeout
  );

endinterface
`default_nettype wire

// File: rtl/aes_wdog.sv
`default_nettype none
// ============================================================================
// Module   : aes_wdog
// Purpose  : Core-wait watchdog. Counts enabled cycles since the last clear
//            and flags expiry on the WDOG_CYCLES-th enabled cycle.
// Revision : 1.0 - initial release
// ============================================================================
module aes_wdog #(
  parameter int WDOG_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int               CNT_W  = $clog2(WDOG_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WDOG_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // The count holds the number of enabled cycles already elapsed, so the
  // current cycle is the last allowed one when it equals WDOG_CYCLES-1.
  assign expire = enable && (r_count == C_LAST);

  // Cycle counter: cleared on ISSUE, saturates once expired.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_count <= '0;
    else if (clear)
      r_count <= '0;
    else if (enable && !expire)
      r_count <= r_count + CNT_W'(1);
  end

endmodule
`default_nettype wire

// File: rtl/aes_ctr_sched.sv
`default_nettype none
// ============================================================================
// Module   : aes_ctr_sched
// Purpose  : CTR-mode sequencing controller for a shared AES round engine.
//            Loads key/nonce, pulses core init/next, builds counter blocks
//            {nonce, ctr} and XORs the keystream into the plaintext stream.
// Options  : AES_CTR_PREFETCH_EN - precompute one keystream block while idle
// Revision : 1.0 - initial release
// ============================================================================
module aes_ctr_sched
  import aes_pkg::*;
#(
  parameter logic [CTR_W-1:0] CTR_INIT    = 64'h0,
  parameter int               WDOG_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  aes_ctr_sched_if.master  bus
);

  state_t             r_state, w_stateNext;
  logic [BLOCK_W-1:0] r_key, r_outData;
  logic [NONCE_W-1:0] r_nonce;
  logic [CTR_W-1:0]   r_ctr;
  logic               r_outValid, r_keyLoaded, r_errWrap, r_errTimeout;
`ifdef AES_CTR_PREFETCH_EN
  logic [BLOCK_W-1:0] r_ksBuf;
  logic               r_ksValid;
`else
  logic [BLOCK_W-1:0] r_data;
`endif

  logic w_coreInit, w_coreNext, w_cfgReady, w_inReady;
  logic w_keyAccept, w_blkAccept, w_keyDone, w_blkDone, w_timeout, w_outDone;
  logic w_wdogClr, w_wdogEn, w_wdogExp;

  aes_wdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_wdogClr),
    .enable (w_wdogEn),
    .expire (w_wdogExp)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_stateNext;
  end

  // Next-state decode plus the per-cycle strobes that drive core and datapath.
  always_comb begin
    w_stateNext = r_state;
    w_coreInit  = 1'b0;
    w_coreNext  = 1'b0;
    w_cfgReady  = 1'b0;
    w_inReady   = 1'b0;
    w_keyAccept = 1'b0;
    w_blkAccept = 1'b0;
    w_keyDone   = 1'b0;
    w_blkDone   = 1'b0;
    w_timeout   = 1'b0;
    w_outDone   = 1'b0;
    w_wdogClr   = 1'b0;
    w_wdogEn    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cfgReady = 1'b1;
`ifdef AES_CTR_PREFETCH_EN
        w_inReady  = r_keyLoaded && r_ksValid && !bus.cfg_key_valid;
`else
        w_inReady  = r_keyLoaded && !bus.cfg_key_valid;
`endif
        if (bus.cfg_key_valid) begin
          w_keyAccept = 1'b1;
          w_stateNext = ST_KEY_ISSUE;
        end else if (bus.in_valid && w_inReady) begin
          w_blkAccept = 1'b1;
`ifdef AES_CTR_PREFETCH_EN
          w_stateNext = ST_OUT;
        end else if (r_keyLoaded && !r_ksValid) begin
          w_stateNext = ST_BLK_ISSUE;
`else
          w_stateNext = ST_BLK_ISSUE;
`endif
        end
      end
      ST_KEY_ISSUE: begin
        w_coreInit  = 1'b1;
        w_wdogClr   = 1'b1;
        w_stateNext = ST_KEY_ARM;
      end
      ST_KEY_ARM: begin
        w_wdogEn = 1'b1;
        if (w_wdogExp) begin
          w_timeout   = 1'b1;
          w_stateNext = ST_IDLE;
        end else begin
          w_stateNext = ST_KEY_WAIT;
        end
      end
      ST_KEY_WAIT: begin
        w_wdogEn = 1'b1;
        if (bus.core_ready) begin
          w_keyDone   = 1'b1;
          w_stateNext = ST_IDLE;
        end else if (w_wdogExp) begin
          w_timeout   = 1'b1;
          w_stateNext = ST_IDLE;
        end
      end
      ST_BLK_ISSUE: begin
        w_coreNext  = 1'b1;
        w_wdogClr   = 1'b1;
        w_stateNext = ST_BLK_ARM;
      end
      ST_BLK_ARM: begin
        w_wdogEn = 1'b1;
        if (w_wdogExp) begin
          w_timeout   = 1'b1;
          w_stateNext = ST_IDLE;
        end else begin
          w_stateNext = ST_BLK_WAIT;
        end
      end
      ST_BLK_WAIT: begin
        w_wdogEn = 1'b1;
        if (bus.core_ready) begin
          w_blkDone = 1'b1;
`ifdef AES_CTR_PREFETCH_EN
          w_stateNext = ST_IDLE;
`else
          w_stateNext = ST_OUT;
`endif
        end else if (w_wdogExp) begin
          w_timeout   = 1'b1;
          w_stateNext = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          w_outDone   = 1'b1;
          w_stateNext = ST_IDLE;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Datapath: key/nonce/counter, plaintext or keystream holding, output and flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key        <= '0;
      r_nonce      <= '0;
      r_ctr        <= CTR_INIT;
      r_outData    <= '0;
      r_outValid   <= 1'b0;
      r_keyLoaded  <= 1'b0;
      r_errWrap    <= 1'b0;
      r_errTimeout <= 1'b0;
`ifdef AES_CTR_PREFETCH_EN
      r_ksBuf      <= '0;
      r_ksValid    <= 1'b0;
`else
      r_data       <= '0;
`endif
    end else begin
      if (w_keyAccept) begin
        r_key        <= bus.cfg_key;
        r_nonce      <= bus.cfg_nonce;
        r_ctr        <= CTR_INIT;
        r_keyLoaded  <= 1'b0;
        r_errWrap    <= 1'b0;
        r_errTimeout <= 1'b0;
`ifdef AES_CTR_PREFETCH_EN
        r_ksValid    <= 1'b0;
`endif
      end
      if (w_blkAccept) begin
`ifdef AES_CTR_PREFETCH_EN
        r_outData  <= bus.in_data ^ r_ksBuf;
        r_outValid <= 1'b1;
        r_ksValid  <= 1'b0;
`else
        r_data     <= bus.in_data;
`endif
      end
      if (w_keyDone)
        r_keyLoaded <= 1'b1;
      if (w_blkDone) begin
        r_ctr <= r_ctr + CTR_W'(1);
        if (&r_ctr)
          r_errWrap <= 1'b1;
`ifdef AES_CTR_PREFETCH_EN
        r_ksBuf    <= bus.core_result;
        r_ksValid  <= 1'b1;
`else
        r_outData  <= r_data ^ bus.core_result;
        r_outValid <= 1'b1;
`endif
      end
      if (w_timeout) begin
        r_errTimeout <= 1'b1;
        r_keyLoaded  <= 1'b0;
      end
      if (w_outDone)
        r_outValid <= 1'b0;
    end
  end

  assign bus.cfg_key_ready = w_cfgReady;
  assign bus.in_ready      = w_inReady;
  assign bus.key_loaded    = r_keyLoaded;
  assign bus.out_valid     = r_outValid;
  assign bus.out_data      = r_outData;
  assign bus.core_init     = w_coreInit;
  assign bus.core_next     = w_coreNext;
  assign bus.core_key      = r_key;
  assign bus.core_block    = {r_nonce, r_ctr};
  assign bus.blk_count     = r_ctr;
  assign bus.err_wrap      = r_errWrap;
  assign bus.err_timeout   = r_errTimeout;

endmodule
`default_nettype wire

// File: tb/tb_aes_ctr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_ctr_sched
// Purpose  : Self-checking bench for aes_ctr_sched with a behavioural AES core
//            stand-in and a scoreboard of expected counter blocks/ciphertext.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_ctr_sched;

  localparam logic [63:0] C_CTR_INIT = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam int          C_WDOG     = 16;

  logic clk;
  logic rstN;

  aes_ctr_sched_if bus ();

  aes_ctr_sched #(.CTR_INIT(C_CTR_INIT), .WDOG_CYCLES(C_WDOG)) dut (
    .clk   (clk),
    .reset (rstN),
    .bus   (bus)
  );

  int nAsserts = 0;
  int nFail    = 0;
  int initCount = 0;
  int nextCount = 0;
  int outHsCount = 0;

  logic [127:0] expBlk[$];
  logic [127:0] expOut[$];

  logic [127:0] mKey;
  logic [63:0]  mNonce;
  logic [63:0]  mCtr;

  int           coreDelay;
  bit           coreStuck;
  bit           coreBusy;
  int           coreCnt;
  logic [127:0] coreRes;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in keystream function shared by the core model and the scoreboard.
  function automatic logic [127:0] ksModel(input logic [127:0] blk, input logic [127:0] key);
    ksModel = {blk[63:0], blk[127:64]} ^ {blk[95:0], blk[127:96]} ^ key
              ^ 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Core model: ready drops the cycle after a pulse, returns coreDelay cycles later.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      coreBusy <= 1'b0;
      coreCnt  <= 0;
      coreRes  <= '0;
    end else if (bus.core_init || bus.core_next) begin
      coreBusy <= 1'b1;
      coreCnt  <= coreDelay;
      if (bus.core_next) coreRes <= ksModel(bus.core_block, bus.core_key);
    end else if (coreBusy && !coreStuck) begin
      if (coreCnt <= 1) coreBusy <= 1'b0;
      else              coreCnt  <= coreCnt - 1;
    end
  end
  assign bus.core_ready  = !coreBusy;
  assign bus.core_result = coreRes;

  // Monitor: count pulses, check counter blocks and ciphertext against the scoreboard.
  always @(negedge clk) begin
    if (rstN) begin
      if (bus.core_init) initCount++;
      if (bus.core_next) begin
        nextCount++;
        chk("core_next_expected", 128'(expBlk.size() > 0), 128'd1);
        if (expBlk.size() > 0) chk("core_block", bus.core_block, expBlk.pop_front());
      end
      if (bus.out_valid && bus.out_ready) begin
        outHsCount++;
        chk("out_expected", 128'(expOut.size() > 0), 128'd1);
        if (expOut.size() > 0) chk("out_data", bus.out_data, expOut.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic loadKey(input logic [127:0] k, input logic [63:0] n,
                         input bit alsoIn, input logic [127:0] pt);
    int w;
    bus.cfg_key_valid = 1'b1;
    bus.cfg_key       = k;
    bus.cfg_nonce     = n;
    if (alsoIn) begin
      bus.in_valid = 1'b1;
      bus.in_data  = pt;
    end
    @(negedge clk);
    chk("cfg_key_ready_idle", 128'(bus.cfg_key_ready), 128'd1);
    if (alsoIn) chk("in_ready_key_wins", 128'(bus.in_ready), 128'd0);
    @(posedge clk); #1;
    bus.cfg_key_valid = 1'b0;
    bus.in_valid      = 1'b0;
    mKey   = k;
    mNonce = n;
    mCtr   = C_CTR_INIT;
    @(negedge clk);
    chk("key_loaded_cleared", 128'(bus.key_loaded), 128'd0);
    w = 0;
    while (!bus.key_loaded && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("key_loaded_set", 128'(bus.key_loaded), 128'd1);
    @(posedge clk); #1;
  endtask

  task automatic sendBlock(input logic [127:0] pt, input bit expectOut, output int lat);
    int w;
    bus.in_valid = 1'b1;
    bus.in_data  = pt;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_wait", 128'(bus.in_ready), 128'd1);
    expBlk.push_back({mNonce, mCtr});
    if (expectOut) begin
      expOut.push_back(pt ^ ksModel({mNonce, mCtr}, mKey));
      mCtr = mCtr + 64'd1;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && !bus.err_timeout && lat < 60);
  endtask

  int lat;
  int nb;
  int hs;
  logic [127:0] held;

  initial begin
    bus.cfg_key_valid = 1'b0;
    bus.cfg_key       = '0;
    bus.cfg_nonce     = '0;
    bus.in_valid      = 1'b0;
    bus.in_data       = '0;
    bus.out_ready     = 1'b1;
    coreDelay = 5;
    coreStuck = 1'b0;
    rstN = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cfg_key_ready", 128'(bus.cfg_key_ready), 128'd1);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_out_data", bus.out_data, 128'd0);
    chk("rst_key_loaded", 128'(bus.key_loaded), 128'd0);
    chk("rst_in_ready", 128'(bus.in_ready), 128'd0);
    chk("rst_blk_count", 128'(bus.blk_count), 128'(C_CTR_INIT));
    chk("rst_core_key", bus.core_key, 128'd0);
    chk("rst_err_wrap", 128'(bus.err_wrap), 128'd0);
    chk("rst_err_timeout", 128'(bus.err_timeout), 128'd0);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;

    // Key load with a slow core
    loadKey(128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0, '0);
    chk("init_pulses", 128'(initCount), 128'd1);
    chk("key_blk_count", 128'(bus.blk_count), 128'(C_CTR_INIT));
    chk("core_key", bus.core_key, 128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F);

    // Three back-to-back blocks with an ideal core, crossing the counter wrap
    coreDelay = 1;
    sendBlock(128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b1, lat);
    chk("latency_ideal", 128'(lat), 128'd4);
    chk("wrap_not_yet", 128'(bus.err_wrap), 128'd0);
    chk("blk_count_ffff", 128'(bus.blk_count), 128'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1;
    sendBlock(128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1234_5678, 1'b1, lat);
    chk("err_wrap_set", 128'(bus.err_wrap), 128'd1);
    chk("blk_count_wrapped", 128'(bus.blk_count), 128'd0);
    @(posedge clk); #1;
    sendBlock(128'hFFFF_0000_FFFF_0000_AAAA_5555_AAAA_5555, 1'b1, lat);
    @(posedge clk); #1;
    chk("next_pulses_3", 128'(nextCount), 128'd3);
    chk("blk_count_after3", 128'(bus.blk_count), 128'd1);
    chk("err_wrap_sticky", 128'(bus.err_wrap), 128'd1);
    chk("out_drained_3", 128'(expOut.size()), 128'd0);

    // Output backpressure for 10 cycles
    bus.out_ready = 1'b0;
    sendBlock(128'h0F0F_0F0F_F0F0_F0F0_1357_9BDF_2468_ACE0, 1'b1, lat);
    held = expOut[0];
    nb = nextCount;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 128'h7777_7777_7777_7777_7777_7777_7777_7777;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_out_valid", 128'(bus.out_valid), 128'd1);
      chk("stall_out_data", bus.out_data, held);
      chk("stall_in_ready", 128'(bus.in_ready), 128'd0);
    end
    chk("stall_no_next", 128'(nextCount), 128'(nb));
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("stall_drained", 128'(expOut.size()), 128'd0);

    // Key load and plaintext requested together: key load wins
    nb = nextCount;
    loadKey(128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978, 64'h0123_4567_89AB_CDEF,
            1'b1, 128'h9999_9999_9999_9999_9999_9999_9999_9999);
    chk("both_init_pulses", 128'(initCount), 128'd2);
    chk("both_no_next", 128'(nextCount), 128'(nb));
    chk("reload_err_wrap_clr", 128'(bus.err_wrap), 128'd0);
    chk("reload_blk_count", 128'(bus.blk_count), 128'(C_CTR_INIT));

    // Core stuck busy: watchdog expiry drops the block
    coreStuck = 1'b1;
    hs = outHsCount;
    sendBlock(128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA, 1'b0, lat);
    chk("timeout_latency", 128'(lat), 128'd18);
    chk("err_timeout_set", 128'(bus.err_timeout), 128'd1);
    chk("timeout_key_loaded", 128'(bus.key_loaded), 128'd0);
    chk("timeout_out_valid", 128'(bus.out_valid), 128'd0);
    chk("timeout_blk_count", 128'(bus.blk_count), 128'(C_CTR_INIT));
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("timeout_in_ready", 128'(bus.in_ready), 128'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("timeout_no_out", 128'(outHsCount), 128'(hs));

    // Recovery: key reload clears the timeout and streaming resumes
    coreStuck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    loadKey(128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0, '0);
    chk("reload_err_timeout_clr", 128'(bus.err_timeout), 128'd0);
    sendBlock(128'h0123_0123_0123_0123_4567_4567_4567_4567, 1'b1, lat);
    chk("latency_recover", 128'(lat), 128'd4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("final_out_empty", 128'(expOut.size()), 128'd0);
    chk("final_blk_empty", 128'(expBlk.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_ctr_sched.md
Name: aes_ctr_sched

Overview:
Sequencing controller for the shared AES round engine (key expansion plus encryption core on one S-box) in CTR mode. It loads keys, drives init/next pulses, and builds counter blocks from a latched nonce and an internal block counter. It XORs the returned keystream with streamed plaintext and presents results on a valid/ready output. It sits between the stream interface and the AES core, replacing ad-hoc top-level init/next control.

Parameters:
CTR_INIT, 64'h0, block-counter value loaded on every key load
WDOG_CYCLES, 64, max cycles allowed in any core-wait state before timeout (>=2)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
cfg_key_valid  input  1  request key/nonce load
cfg_key  input  128  AES key, sampled with cfg_key_valid
cfg_nonce  input  64  nonce, sampled with cfg_key_valid
cfg_key_ready  output  1  high only in IDLE; load accepted when valid&&ready
key_loaded  output  1  key expansion completed, no timeout since
in_valid  input  1  plaintext block valid
in_data  input  128  plaintext block
in_ready  output  1  plaintext accepted when valid&&ready
out_valid  output  1  ciphertext valid, held until out_ready
out_data  output  128  ciphertext = in_data ^ keystream
out_ready  input  1  downstream accept
core_init  output  1  one-cycle key-expansion start pulse
core_next  output  1  one-cycle block-encrypt start pulse
core_key  output  128  latched key
core_block  output  128  {nonce_q, ctr_q}
core_ready  input  1  core idle/done (registered in core, drops 1 cycle after pulse)
core_result  input  128  keystream block
blk_count  output  64  current ctr_q
err_wrap  output  1  sticky: ctr wrapped all-ones->0
err_timeout  output  1  sticky: watchdog expired

Behaviour:
- Reset: all outputs 0, except cfg_key_ready=1. State IDLE. ctr_q=CTR_INIT, key/nonce regs 0.
- States:
  - IDLE: cfg_key_valid wins over in_valid on the same cycle. A key load latches key/nonce, sets ctr_q=CTR_INIT, clears err_wrap and err_timeout, drops key_loaded -> KEY_ISSUE. Otherwise in_valid&&key_loaded latches in_data -> BLK_ISSUE.
  - KEY_ISSUE: core_init=1 for exactly one cycle -> KEY_ARM.
  - KEY_ARM: one cycle, core_ready ignored -> KEY_WAIT.
  - KEY_WAIT: core_ready=1 -> key_loaded=1 -> IDLE.
  - BLK_ISSUE: core_next=1 for one cycle, core_block stable -> BLK_ARM.
  - BLK_ARM: one cycle -> BLK_WAIT.
  - BLK_WAIT: core_ready=1 -> out_data<=data_q^core_result, out_valid<=1, ctr_q<=ctr_q+1 (mod 2^64) -> OUT.
  - OUT: hold out_valid and out_data until out_ready -> IDLE. If out_ready is already high on entry, leave next cycle.
- in_ready and cfg_key_ready are combinational: 1 only in IDLE. in_ready also requires key_loaded and !cfg_key_valid.
- core_key/core_block stable from ISSUE until wait exit.
- Wrap: increment from 64'hFFFF_FFFF_FFFF_FFFF gives 0 and sets err_wrap. Streaming continues.
- Watchdog: counts cycles in ARM+WAIT and clears on entering ISSUE. Reaching WDOG_CYCLES sets err_timeout, clears key_loaded, drops the pending block (no out_valid) -> IDLE.
- Latency with an ideal core (ready 1 cycle after ARM): in accept to out_valid = 4 cycles.
- Reset mid-operation: immediate return to reset values, pending block discarded.

Optional Feature:
AES_CTR_PREFETCH_EN:
- Defined: adds a 128-bit keystream buffer with a ks_valid flag. In IDLE with key_loaded, !ks_valid and no cfg_key_valid, the controller runs ISSUE/ARM/WAIT for ctr_q without plaintext, stores core_result, sets ks_valid and increments ctr_q. in_ready is 1 when ks_valid; the accepted block goes directly to OUT with out_data=in_data^ks_buf, clearing ks_valid. Key load clears ks_valid.
- Undefined: behaviour exactly as above, no buffer.

Decomposition:
- Shared package aes_pkg: state enum encoding, BLOCK_W=128, CTR_W=64, NONCE_W=64.
- One sub-module, aes_wdog: watchdog counter with clear/enable/expire.

Test Plan:
- Key load key=0x000102..0F, nonce=0xA5A5A5A5_5A5A5A5A, core_ready returns 5 cycles after ARM -> exactly one core_init pulse, key_loaded=1, blk_count=0.
- Three back-to-back blocks, out_ready=1 -> three core_next pulses with core_block low halves 0,1,2; out_data = in_data^core_result; blk_count=3.
- out_ready held 0 for 10 cycles -> out_valid and out_data stable, in_ready=0, no core_next until the handshake completes.
- CTR_INIT=64'hFFFF_FFFF_FFFF_FFFE, two blocks -> counters FFFE, FFFF; blk_count=0; err_wrap=1 after the second block; next key load clears it.
- core_ready stuck 0 with WDOG_CYCLES=16 -> err_timeout at cycle 16 of ARM+WAIT, key_loaded=0, no out_valid, in_ready=0.
- cfg_key_valid and in_valid asserted together in IDLE -> key load wins, plaintext not accepted (in_ready=0).
